uart_rx_frame_checker: RTL
==========================

Name: uart_rx_frame_checker

Overview:
- Receive-side counterpart of the TX parity/serialiser path.
- Accepts one sampled bit per bit period from the RX data sampler, tracks frame position (start, data, optional parity, stop) and deserialises data LSB first.
- Accumulates running parity and checks the received parity and stop bits.
- Delivers the parallel byte with a one-cycle valid strobe, or a one-cycle error strobe instead.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (range 5..9).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- Bit_Valid  input  1  one-cycle strobe: Sampled_Bit holds the settled value of the current bit period.
- Sampled_Bit  input  1  majority-voted serial bit from the sampler.
- Par_En  input  1  1 = frame carries a parity bit.
- Par_Type  input  1  0 = even, 1 = odd; same encoding as TX.
- P_Data  output  DATA_WIDTH  last good received word.
- Data_Valid  output  1  one-cycle strobe: P_Data updated, frame error-free.
- Par_Err  output  1  one-cycle strobe: parity mismatch in the completed frame.
- Stp_Err  output  1  one-cycle strobe: stop bit sampled 0.
- Busy  output  1  high from accepted start bit until frame end.

Behaviour:
- Reset (RST low, async): state IDLE; P_Data=0, Data_Valid=0, Par_Err=0, Stp_Err=0, Busy=0; bit counter, shift register and parity accumulator cleared.
- All outputs are registered. The FSM advances only on cycles with Bit_Valid=1; it holds state otherwise.
- IDLE:
  - Bit_Valid & Sampled_Bit=0 → DATA. Latch Par_En/Par_Type into frame-local copies, clear counter and parity accumulator, set Busy.
  - Bit_Valid & Sampled_Bit=1 → stay IDLE (line idle or false start).
- DATA: each Bit_Valid does the following:
  - shift Sampled_Bit into the MSB of the shift register (LSB-first reception);
  - parity_acc ^= Sampled_Bit;
  - counter++.
  - After the DATA_WIDTH-th bit → PARITY if the latched Par_En=1, else → STOP.
- PARITY:
  - Expected bit = parity_acc ^ latched Par_Type.
  - On Bit_Valid, register the mismatch flag (Sampled_Bit != expected) → STOP.
- STOP: on Bit_Valid → IDLE, clear Busy, then exactly one of the following on the next cycle:
  - Sampled_Bit=0: Stp_Err=1. Par_Err is also 1 if the parity mismatch flag is set. Data_Valid=0 and P_Data unchanged.
  - Sampled_Bit=1 and mismatch set: Par_Err=1. Data_Valid=0 and P_Data unchanged.
  - Sampled_Bit=1 and no mismatch: P_Data <= shift register, Data_Valid=1.
- Latency: strobes assert on the cycle after the CLK edge that accepted the stop bit. Each strobe lasts exactly one cycle.
- P_Data holds its value until the next error-free frame completes.
- Par_En/Par_Type changes mid-frame have no effect; the latched copies govern the whole frame.
- Back-to-back frames: a start bit arriving on the Bit_Valid immediately after the stop bit is accepted normally from IDLE. No dead period is required.
- Bit_Valid held high on consecutive cycles: each cycle counts as one bit.
- RST asserted mid-frame: immediate abort to IDLE with reset values. No strobe is emitted for the partial frame.
- Combinational loops and latches are prohibited. The parity accumulator width is 1 bit.

Test Plan:
- Even parity, DATA_WIDTH=8, 0xA5. Bit sequence: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1. Expect P_Data=0xA5, Data_Valid high 1 cycle after stop, Par_Err=Stp_Err=0, Busy high for the 11 bits.
- Odd parity, 0xA5 with parity bit 1. Expect Data_Valid, no error. Repeat with parity bit 0: expect Par_Err 1 cycle, Data_Valid=0, P_Data still 0xA5.
- Par_En=0, 0x3C (data 0,0,1,1,1,1,0,0), stop 1. Expect P_Data=0x3C after 10 bits. Then send stop=0 on a 0x55 frame: expect Stp_Err pulse, P_Data stays 0x3C.
- False start and idle. Send Bit_Valid with Sampled_Bit=1 ×5: state stays IDLE, Busy=0, no strobes. Insert 3-cycle gaps between Bit_Valid strobes inside a frame (0x81, even parity 0): result unaffected.
- Mid-frame config change and back-to-back frames. Toggle Par_Type after the 3rd data bit: the original type is used. A second frame whose start bit arrives on the Bit_Valid right after the first stop is received correctly (0x0F then 0xF0).
- Reset mid-frame. Assert RST low after the 4th data bit of 0xFF: outputs return to 0 immediately. After release, a clean frame of 0x12 (even parity 0) yields Data_Valid with P_Data=0x12.

Source files
------------

// File: rtl/uart_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_checker
// Brief    : UART receive frame tracker. Consumes one sampled bit per bit
//            period, deserialises data LSB first, checks optional parity and
//            the stop bit, and reports a good word or an error with a
//            single-cycle strobe.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Bit_Valid,
    input  logic                  Sampled_Bit,
    input  logic                  Par_En,
    input  logic                  Par_Type,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err,
    output logic                  Busy
);

    // Counter only needs to reach DATA_WIDTH-1 (last data bit index).
    localparam int                 c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_acc;
    logic                    r_par_en;
    logic                    r_par_type;
    logic                    r_mismatch;

    state_t                  w_state_nxt;
    logic [c_CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   w_shift_nxt;
    logic                    w_par_acc_nxt;
    logic                    w_par_en_nxt;
    logic                    w_par_type_nxt;
    logic                    w_mismatch_nxt;
    logic [DATA_WIDTH-1:0]   w_p_data_nxt;
    logic                    w_data_valid_nxt;
    logic                    w_par_err_nxt;
    logic                    w_stp_err_nxt;
    logic                    w_busy_nxt;

    // State and output registers; async active-low reset aborts any frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_par_acc  <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_mismatch <= 1'b0;
            P_Data     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_par_acc  <= w_par_acc_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_type <= w_par_type_nxt;
            r_mismatch <= w_mismatch_nxt;
            P_Data     <= w_p_data_nxt;
            Data_Valid <= w_data_valid_nxt;
            Par_Err    <= w_par_err_nxt;
            Stp_Err    <= w_stp_err_nxt;
            Busy       <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a bit arrives,
    // and the strobes fall back to zero every cycle so they last one cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_par_acc_nxt    = r_par_acc;
        w_par_en_nxt     = r_par_en;
        w_par_type_nxt   = r_par_type;
        w_mismatch_nxt   = r_mismatch;
        w_p_data_nxt     = P_Data;
        w_data_valid_nxt = 1'b0;
        w_par_err_nxt    = 1'b0;
        w_stp_err_nxt    = 1'b0;
        w_busy_nxt       = Busy;

        if (Bit_Valid) begin
            case (r_state)
                IDLE: begin
                    // A low bit is a start bit; a high bit is idle line.
                    if (!Sampled_Bit) begin
                        w_state_nxt    = DATA;
                        w_par_en_nxt   = Par_En;
                        w_par_type_nxt = Par_Type;
                        w_cnt_nxt      = '0;
                        w_par_acc_nxt  = 1'b0;
                        w_mismatch_nxt = 1'b0;
                        w_busy_nxt     = 1'b1;
                    end
                end
                DATA: begin
                    // Shift in at the MSB so the first (LSB) bit ends at bit 0.
                    w_shift_nxt   = {Sampled_Bit, r_shift[DATA_WIDTH-1:1]};
                    w_par_acc_nxt = r_par_acc ^ Sampled_Bit;
                    w_cnt_nxt     = r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    w_mismatch_nxt = Sampled_Bit != (r_par_acc ^ r_par_type);
                    w_state_nxt    = STOP;
                end
                STOP: begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    if (!Sampled_Bit) begin
                        w_stp_err_nxt = 1'b1;
                        w_par_err_nxt = r_mismatch;
                    end else if (r_mismatch) begin
                        w_par_err_nxt = 1'b1;
                    end else begin
                        w_p_data_nxt     = r_shift;
                        w_data_valid_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
